// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronises, locks, counts errors and drops lock on error bursts.
// Optional macro PRBS31_CHK_INV_EN adds an 'inv' input that complements the incoming stream.
module prbs31_checker #(
    parameter int CNT_W      = 16,
    parameter int VERIFY_LEN = 32,
    parameter int LOSS_WIN   = 64,
    parameter int LOSS_THR   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
`ifdef PRBS31_CHK_INV_EN
    input  logic             inv,
`endif
    input  logic             din_vld,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int VER_W = $clog2(VERIFY_LEN + 1);
    localparam int WIN_W = $clog2(LOSS_WIN + 1);
    localparam int THR_W = $clog2(LOSS_THR + 1);

    localparam logic [VER_W-1:0] VER_LAST  = VER_W'(VERIFY_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(LOSS_WIN - 1);
    localparam logic [THR_W-1:0] THR       = THR_W'(LOSS_THR);
    localparam logic [4:0]       FILL_LAST = 5'd30;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [30:0]       sreg, sreg_nxt, shifted;
    logic [4:0]        fill_cnt, fill_nxt;
    logic [VER_W-1:0]  ver_cnt, ver_nxt;
    logic [WIN_W-1:0]  win_cnt, win_nxt;
    logic [THR_W-1:0]  win_err, win_err_nxt, win_err_sum;
    logic              bit_in, pred, err_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef PRBS31_CHK_INV_EN
    assign bit_in = din ^ inv;
`else
    assign bit_in = din;
`endif

    assign pred    = sreg[30] ^ sreg[27];
    assign shifted = {sreg[29:0], bit_in};
    assign locked  = (state == LOCKED);

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        fill_nxt    = fill_cnt;
        ver_nxt     = ver_cnt;
        win_nxt     = win_cnt;
        win_err_nxt = win_err;
        win_err_sum = win_err;
        err_p0      = 1'b0;
        if (din_vld) begin
            case (state)
                SEARCH: begin
                    sreg_nxt = shifted;
                    if (fill_cnt == FILL_LAST) begin
                        fill_nxt = '0;
                        // An all-zero register is a fixed point of the recurrence; never accept it.
                        if (shifted != '0) begin
                            state_nxt = VERIFY;
                            ver_nxt   = '0;
                        end
                    end else begin
                        fill_nxt = fill_cnt + 5'd1;
                    end
                end
                VERIFY: begin
                    sreg_nxt = shifted;
                    if (bit_in != pred) begin
                        state_nxt = SEARCH;
                        fill_nxt  = '0;
                    end else if (ver_cnt == VER_LAST) begin
                        state_nxt   = LOCKED;
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else begin
                        ver_nxt = ver_cnt + VER_W'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a corrupted input bit never seeds later errors.
                    sreg_nxt    = {sreg[29:0], pred};
                    err_p0      = bit_in ^ pred;
                    win_err_sum = win_err + THR_W'(err_p0);
                    if (win_err_sum == THR) begin
                        state_nxt = SEARCH;
                        fill_nxt  = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else begin
                        win_nxt     = win_cnt + WIN_W'(1);
                        win_err_nxt = win_err_sum;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            sreg      <= '0;
            fill_cnt  <= '0;
            ver_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            fill_cnt  <= fill_nxt;
            ver_cnt   <= ver_nxt;
            win_cnt   <= win_nxt;
            win_err   <= win_err_nxt;
            err_pulse <= err_p0;
            if (clr) begin
                err_cnt <= '0;
            end else if (err_p0) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: the driver queues the expected lock/pulse/count after each edge,
// a monitor pops and compares one entry per clock.
module tb_prbs31_checker;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, din, din_vld, clr;
`ifdef PRBS31_CHK_INV_EN
    logic          inv;
`endif
    logic          locked, err_pulse;
    logic [CW-1:0] err_cnt;

    prbs31_checker #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
`ifdef PRBS31_CHK_INV_EN
        .inv      (inv),
`endif
        .din_vld  (din_vld),
        .clr      (clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic          lock;
        logic          pulse;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [30:0] gstate;
    int          lpos;

    function automatic string tag_name(input int t);
        case (t)
            0:  return "reset";
            1:  return "clean_lock";
            2:  return "single_flip";
            3:  return "window_straddle_sat";
            4:  return "clr";
            5:  return "loss_relock";
            6:  return "vld_gaps";
            7:  return "rst_mid_lock";
            8:  return "all_zero";
            9:  return "verify_break";
            10: return "inverted";
            default: return "unknown";
        endcase
    endfunction

    // Reference PRBS31 generator, same polynomial as the stream under test.
    task automatic gen(output logic b);
        b      = gstate[30] ^ gstate[27];
        gstate = {gstate[29:0], b};
    endtask

    task automatic drive(input logic d, input logic v, input logic c, input logic r,
                         input int tag, input logic el, input logic ep, input int ec);
        exp_t e;
        @(negedge clk);
        din     = d;
        din_vld = v;
        clr     = c;
        rst     = r;
        e.tag   = tag;
        e.lock  = el;
        e.pulse = ep;
        e.cnt   = CW'(ec);
        sb.push_back(e);
    endtask

    task automatic bit_out(input logic flip, input logic c, input int tag,
                           input logic el, input logic ep, input int ec);
        logic b;
        gen(b);
        drive(b ^ flip, 1'b1, c, 1'b0, tag, el, ep, ec);
        lpos++;
    endtask

    task automatic advance_to(input int pos, input int tag, input int ec);
        while (lpos % 64 != pos) bit_out(1'b0, 1'b0, tag, 1'b1, 1'b0, ec);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vectors++;
            if (locked !== mon_e.lock || err_pulse !== mon_e.pulse || err_cnt !== mon_e.cnt) begin
                miscompares++;
                $display("FAIL %s: locked/err_pulse/err_cnt got %b/%b/%0d, required %b/%b/%0d",
                         tag_name(mon_e.tag), locked, err_pulse, err_cnt,
                         mon_e.lock, mon_e.pulse, mon_e.cnt);
            end
        end
    end

    initial begin
        logic gb;
        int   nv;
        rst = 1'b1; din = 1'b0; din_vld = 1'b0; clr = 1'b0;
`ifdef PRBS31_CHK_INV_EN
        inv = 1'b0;
`endif
        gstate = 31'h7FFFFFFF;
        lpos   = 0;

        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);

        // Clean stream: lock after 31 fill + 32 verify bits, then 10000 bits error-free.
        for (int n = 1; n <= 10000; n++) begin
            bit_out(1'b0, 1'b0, 1, (n >= 63), 1'b0, 0);
            if (n == 63) lpos = 0;
        end

        // One flipped bit: single pulse, count 1, no error multiplication.
        bit_out(1'b1, 1'b0, 2, 1'b1, 1'b1, 1);
        for (int i = 0; i < 100; i++) bit_out(1'b0, 1'b0, 2, 1'b1, 1'b0, 1);

        // 7 errors closing one window + 7 opening the next: stays locked; count saturates at 15.
        advance_to(57, 3, 1);
        for (int k = 0; k < 14; k++) bit_out(1'b1, 1'b0, 3, 1'b1, 1'b1, (2 + k > 15) ? 15 : 2 + k);
        advance_to(0, 3, 15);
        for (int k = 0; k < 3; k++) bit_out(1'b1, 1'b0, 3, 1'b1, 1'b1, 15);

        bit_out(1'b0, 1'b1, 4, 1'b1, 1'b0, 0);

        // 8 errors ending on the window-closing bit: lock drops on the 8th, relock 63 bits later.
        advance_to(0, 5, 0);
        advance_to(56, 5, 0);
        for (int k = 0; k < 8; k++) bit_out(1'b1, 1'b0, 5, (k < 7), 1'b1, k + 1);
        for (int n = 1; n <= 63; n++) begin
            bit_out(1'b0, 1'b0, 5, (n >= 63), 1'b0, 8);
            if (n == 63) lpos = 0;
        end
        for (int i = 0; i < 20; i++) bit_out(1'b0, 1'b0, 5, 1'b1, 1'b0, 8);

        // Random valid gaps with junk data on idle cycles.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b0, 0);
        gstate = 31'h7FFFFFFF;
        nv = 0;
        while (nv < 150) begin
            if ($urandom_range(0, 1) == 1) begin
                nv++;
                bit_out(1'b0, 1'b0, 6, (nv >= 63), 1'b0, 0);
                if (nv == 63) lpos = 0;
            end else begin
                drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 6, (nv >= 63), 1'b0, 0);
            end
        end
        bit_out(1'b1, 1'b0, 6, 1'b1, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0, 1);
        bit_out(1'b1, 1'b1, 6, 1'b1, 1'b1, 0);
        bit_out(1'b0, 1'b0, 6, 1'b1, 1'b0, 0);

        // Reset while locked with count 5 and an error presented on the same edge.
        advance_to(0, 7, 0);
        for (int k = 1; k <= 5; k++) begin
            bit_out(1'b1, 1'b0, 7, 1'b1, 1'b1, k);
            repeat (3) bit_out(1'b0, 1'b0, 7, 1'b1, 1'b0, k);
        end
        gen(gb);
        drive(~gb, 1'b1, 1'b0, 1'b1, 7, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0);
        for (int n = 1; n <= 70; n++) bit_out(1'b0, 1'b0, 7, (n >= 63), 1'b0, 0);

        // Mismatch during verify restarts acquisition: bit 41 bad, lock after bit 104.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0, 0);
        gstate = 31'h7FFFFFFF;
        for (int n = 1; n <= 40; n++) bit_out(1'b0, 1'b0, 9, 1'b0, 1'b0, 0);
        bit_out(1'b1, 1'b0, 9, 1'b0, 1'b0, 0);
        for (int n = 42; n <= 110; n++) bit_out(1'b0, 1'b0, 9, (n >= 104), 1'b0, 0);

        // Constant zero never locks.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 0);
        for (int i = 0; i < 500; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0);

`ifdef PRBS31_CHK_INV_EN
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 0);
        gstate = 31'h7FFFFFFF;
        inv = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            gen(gb);
            drive(~gb, 1'b1, 1'b0, 1'b0, 10, (n >= 63), 1'b0, 0);
        end
`endif

        for (int i = 0; i < 10; i++) begin
            if (sb.size() > 0) @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
